// File: rtl/wave_dds_gen_pkg.sv
// Shared types and constants for the DDS waveform generator.
// The default duty is kept as a left-aligned fraction so any OUT_W can take its top bits.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'd0,
        MODE_SAW_DN = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQR    = 2'd3
    } mode_e;

    // 50 % duty expressed as a 32-bit fraction; users slice the top OUT_W bits.
    localparam logic [31:0] DUTY_DEFAULT_FRAC = 32'h8000_0000;

endpackage

// File: rtl/wave_dds_gen_shaper.sv
// Combinational phase-to-sample mapping for saw-up, saw-down, triangle and square.
module wave_shaper
    import wave_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic [OUT_W-1:0] phase_i,
    input  mode_e            mode_i,
    input  logic [OUT_W-1:0] duty_i,
    output logic [OUT_W-1:0] sample_o
);

    logic [OUT_W-1:0] tri_s;

    // Map the phase to a sample; the triangle doubles the slope and folds on the phase MSB.
    always_comb begin
        tri_s    = {phase_i[OUT_W-2:0], 1'b0};
        sample_o = '0;
        case (mode_i)
            MODE_SAW_UP: sample_o = phase_i;
            MODE_SAW_DN: sample_o = ~phase_i;
            MODE_TRI: begin
                if (phase_i[OUT_W-1]) begin
                    sample_o = ~tri_s;
                end else begin
                    sample_o = tri_s;
                end
            end
            MODE_SQR: begin
                if (phase_i < duty_i) begin
                    sample_o = '1;
                end else begin
                    sample_o = '0;
                end
            end
            default: sample_o = '0;
        endcase
    end

endmodule

// File: rtl/wave_dds_gen.sv
// Phase-accumulator waveform generator with double-buffered settings applied at period boundaries.
// Owns the accumulator, pending/active setting registers, the output register and wrap/busy flags.
module wave_dds_gen
    import wave_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [ACC_W-1:0] ftw,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] duty,
    input  logic             phase_rst,
    output logic [OUT_W-1:0] value,
    output logic             wrap,
    output logic             busy
);

    localparam logic [OUT_W-1:0] DUTY_DEF = DUTY_DEFAULT_FRAC[31 -: OUT_W];

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
    logic [ACC_W-1:0] ftw_pend_q, ftw_pend_d;
    mode_e            mode_act_q, mode_act_d;
    mode_e            mode_pend_q, mode_pend_d;
    logic [OUT_W-1:0] duty_act_q, duty_act_d;
    logic [OUT_W-1:0] duty_pend_q, duty_pend_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic             apply_s;
    logic [OUT_W-1:0] sample_s;

    wave_shaper #(
        .OUT_W (OUT_W)
    ) u_shaper (
        .phase_i  (acc_q[ACC_W-1 -: OUT_W]),
        .mode_i   (mode_act_q),
        .duty_i   (duty_act_q),
        .sample_o (sample_s)
    );

    // Next-state logic: accumulate, shape, and swap pending settings in at a boundary.
    always_comb begin
        sum_s       = {1'b0, acc_q} + {1'b0, ftw_act_q};
        carry_s     = sum_s[ACC_W];
        acc_d       = acc_q;
        value_d     = value_q;
        wrap_d      = 1'b0;
        ftw_act_d   = ftw_act_q;
        mode_act_d  = mode_act_q;
        duty_act_d  = duty_act_q;
        ftw_pend_d  = ftw_pend_q;
        mode_pend_d = mode_pend_q;
        duty_pend_d = duty_pend_q;
        busy_d      = busy_q;

        // A stalled generator (ftw_act==0) would never wrap, so it takes settings at once.
        apply_s = busy_q & (phase_rst
                            | (ena & carry_s)
                            | (ftw_act_q == '0));

        if (phase_rst) begin
            acc_d   = '0;
            value_d = '0;
        end else if (ena) begin
            acc_d   = sum_s[ACC_W-1:0];
            value_d = sample_s;
            wrap_d  = carry_s;
        end else begin
            acc_d   = acc_q;
        end

        if (apply_s) begin
            ftw_act_d  = ftw_pend_q;
            mode_act_d = mode_pend_q;
            duty_act_d = duty_pend_q;
            busy_d     = 1'b0;
        end else begin
            ftw_act_d  = ftw_act_q;
        end

        // A load in an apply cycle becomes the next pending set, so busy is re-raised.
        if (load) begin
            ftw_pend_d  = ftw;
            mode_pend_d = mode_e'(mode);
            duty_pend_d = duty;
            busy_d      = 1'b1;
        end else begin
            ftw_pend_d  = ftw_pend_q;
        end
    end

    // State registers with asynchronous clear to the power-on settings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            value_q     <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            ftw_act_q   <= '0;
            mode_act_q  <= MODE_SAW_UP;
            duty_act_q  <= DUTY_DEF;
            ftw_pend_q  <= '0;
            mode_pend_q <= MODE_SAW_UP;
            duty_pend_q <= '0;
        end else begin
            acc_q       <= acc_d;
            value_q     <= value_d;
            wrap_q      <= wrap_d;
            busy_q      <= busy_d;
            ftw_act_q   <= ftw_act_d;
            mode_act_q  <= mode_act_d;
            duty_act_q  <= duty_act_d;
            ftw_pend_q  <= ftw_pend_d;
            mode_pend_q <= mode_pend_d;
            duty_pend_q <= duty_pend_d;
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_wave_dds_gen.sv
// Directed self-checking bench for wave_dds_gen (ACC_W=16, OUT_W=8).
module tb_wave_dds_gen;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        load;
    logic [15:0] ftw;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic        phase_rst;
    logic [7:0]  value;
    logic        wrap;
    logic        busy;

    int checks_cnt;
    int errors_cnt;

    wave_dds_gen #(
        .ACC_W (16),
        .OUT_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load      (load),
        .ftw       (ftw),
        .mode      (mode),
        .duty      (duty),
        .phase_rst (phase_rst),
        .value     (value),
        .wrap      (wrap),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] f, input logic [1:0] m, input logic [7:0] d);
        load = 1'b1;
        ftw  = f;
        mode = m;
        duty = d;
        step();
        load = 1'b0;
    endtask

    task automatic sync_phase();
        phase_rst = 1'b1;
        step();
        phase_rst = 1'b0;
        check_val("prst_value", 32'(value), 32'd0);
        check_val("prst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        load       = 1'b0;
        ftw        = 16'h0000;
        mode       = 2'd0;
        duty       = 8'h80;
        phase_rst  = 1'b0;

        #2;
        check_val("rst_value", 32'(value), 32'd0);
        check_val("rst_wrap", 32'(wrap), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // 1. saw-up: load while stalled, apply one cycle later.
        ena = 1'b1;
        do_load(16'h0100, 2'd0, 8'h80);
        check_val("t1_busy_set", 32'(busy), 32'd1);
        step();
        check_val("t1_busy_clr", 32'(busy), 32'd0);
        for (int k = 0; k <= 260; k++) begin
            step();
            check_val("t1_saw", 32'(value), 32'(k % 256));
            check_val("t1_wrap", 32'(wrap), ((k % 256) == 255) ? 32'd1 : 32'd0);
        end

        // 2. triangle.
        do_load(16'h0200, 2'd2, 8'h80);
        check_val("t2_busy", 32'(busy), 32'd1);
        sync_phase();
        for (int k = 1; k <= 260; k++) begin
            int m;
            m = (k - 1) % 128;
            step();
            check_val("t2_tri", 32'(value), (m < 64) ? 32'(4 * m) : 32'(255 - 4 * (m - 64)));
            check_val("t2_wrap", 32'(wrap), (m == 127) ? 32'd1 : 32'd0);
        end

        // 3. square duty 64, then duty 0, then saw-down.
        do_load(16'h0100, 2'd3, 8'd64);
        sync_phase();
        for (int k = 1; k <= 260; k++) begin
            step();
            check_val("t3_sqr64", 32'(value), (((k - 1) % 256) < 64) ? 32'd255 : 32'd0);
        end
        do_load(16'h0100, 2'd3, 8'd0);
        sync_phase();
        for (int k = 1; k <= 70; k++) begin
            step();
            check_val("t3_sqr0", 32'(value), 32'd0);
        end
        do_load(16'h0100, 2'd1, 8'h80);
        sync_phase();
        for (int k = 1; k <= 20; k++) begin
            step();
            check_val("t3_sawdn", 32'(value), 32'(255 - (k - 1)));
        end

        // 4. glitch-free update, last load wins.
        do_load(16'h0100, 2'd0, 8'h80);
        sync_phase();
        for (int j = 1; j <= 101; j++) begin
            step();
            check_val("t4_pre", 32'(value), 32'(j - 1));
        end
        do_load(16'h0200, 2'd0, 8'h80);
        check_val("t4_busy1", 32'(busy), 32'd1);
        check_val("t4_v1", 32'(value), 32'd101);
        do_load(16'h0400, 2'd0, 8'h80);
        check_val("t4_v2", 32'(value), 32'd102);
        for (int j = 104; j <= 259; j++) begin
            step();
            check_val("t4_value", 32'(value), (j <= 256) ? 32'(j - 1) : 32'(4 * (j - 257)));
            check_val("t4_busy", 32'(busy), (j <= 255) ? 32'd1 : 32'd0);
            check_val("t4_wrap", 32'(wrap), (j == 256) ? 32'd1 : 32'd0);
        end

        // 5. enable hold, phase_rst applying a pending ftw=0xFFFF.
        do_load(16'h0100, 2'd0, 8'h80);
        sync_phase();
        for (int k = 1; k <= 50; k++) begin
            step();
        end
        check_val("t5_pre", 32'(value), 32'd49);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check_val("t5_hold_v", 32'(value), 32'd49);
            check_val("t5_hold_w", 32'(wrap), 32'd0);
        end
        ena = 1'b1;
        step();
        check_val("t5_resume", 32'(value), 32'd50);
        do_load(16'hFFFF, 2'd0, 8'h80);
        check_val("t5_busy", 32'(busy), 32'd1);
        check_val("t5_v51", 32'(value), 32'd51);
        sync_phase();
        check_val("t5_prst_wrap", 32'(wrap), 32'd0);
        for (int k = 1; k <= 600; k++) begin
            step();
            check_val("t5_dec", 32'(value), (k == 1) ? 32'd0 : 32'(255 - ((k - 2) >> 8)));
            check_val("t5_wrap", 32'(wrap), (k == 1) ? 32'd0 : 32'd1);
        end

        // 6. async reset with a pending setting, then coincident load/apply.
        do_load(16'h0100, 2'd0, 8'h80);
        check_val("t6_busy", 32'(busy), 32'd1);
        check_val("t6_wrap", 32'(wrap), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_value", 32'(value), 32'd0);
        check_val("t6_rst_wrap", 32'(wrap), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("t6_idle_v", 32'(value), 32'd0);
            check_val("t6_idle_b", 32'(busy), 32'd0);
            check_val("t6_idle_w", 32'(wrap), 32'd0);
        end
        do_load(16'h0100, 2'd0, 8'h80);
        do_load(16'h0800, 2'd0, 8'h80);
        check_val("t6_coinc_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val("t6_coinc_v", 32'(value), 32'(k - 1));
            check_val("t6_coinc_b", 32'(busy), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/wave_dds_gen.md
Name: wave_dds_gen

Overview:
Parametrised phase-accumulator (DDS) waveform generator. It is the successor to the fixed 8-bit sawtooth lookup in the function generator. It produces saw-up, saw-down, triangle and variable-duty square waves at a programmable frequency. Settings are double-buffered and apply only at a period boundary, so mid-period updates cause no glitches. The registered output drives the function-generator output pins and DAC path directly.

Parameters:
ACC_W, 16, phase accumulator width in bits (must be >= OUT_W+1)
OUT_W, 8, output sample width in bits (>= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  advance enable; low = accumulator and output hold
load  in  1  single-cycle strobe; captures ftw/mode/duty into pending registers
ftw  in  ACC_W  frequency tuning word (phase increment per enabled cycle)
mode  in  2  0 saw-up, 1 saw-down, 2 triangle, 3 square
duty  in  OUT_W  square threshold; high while phase < duty
phase_rst  in  1  synchronous phase clear
value  out  OUT_W  registered waveform sample
wrap  out  1  registered one-cycle pulse, one cycle after an accumulator carry
busy  out  1  high while a pending setting awaits application

Behaviour:
- Reset (async, rst_n=0): acc=0, value=0, wrap=0, busy=0.
- Reset also sets the active settings: ftw_act=0, mode_act=0, duty_act=2^(OUT_W-1). Pending registers are cleared.
- Phase: phase = acc[ACC_W-1 -: OUT_W]. Max = 2^OUT_W-1.
- Enabled cycle (ena=1, phase_rst=0): acc <= (acc + ftw_act) mod 2^ACC_W; carry = carry-out of that add.
- Output latency: value <= shape(phase of current acc, mode_act, duty_act). The sample for acc state A appears one cycle after A is held.
- Shape, where t = {phase[OUT_W-2:0],1'b0}:
  - saw-up: phase.
  - saw-down: ~phase.
  - triangle: t when phase MSB=0, ~t when phase MSB=1.
  - square: Max if phase < duty_act, else 0. duty=0 gives constant 0.
- wrap <= carry on enabled cycles, 0 otherwise. It never stays high two cycles unless carry occurs on consecutive cycles (e.g. ftw near 2^ACC_W).
- ena=0: acc, value and actives hold; wrap=0. load is still accepted.
- load: pend_{ftw,mode,duty} <= inputs; busy <= 1. A load while busy overwrites the pending values (last wins).
- Application: pending is copied to active and busy clears at the clock edge ending a cycle where busy=1 and any of:
  - the enabled cycle produces carry;
  - ftw_act==0 (stalled generator, apply immediately);
  - phase_rst=1.
- New actives take effect for the next accumulation and the next value computation.
- load coincident with an apply cycle: the values already pending are applied. The new load becomes pending, busy stays 1, and it applies at the next boundary.
- load when busy=0 and ftw_act==0: apply occurs on the following cycle.
- phase_rst (priority over ena): acc <= 0, value <= 0, wrap <= 0, and pending is applied if busy.
- Reset mid-operation returns all state to reset values immediately. No partial pending state survives.

Decomposition:
- Package wave_pkg holds:
  - the mode typedef (2-bit enum MODE_SAW_UP, MODE_SAW_DN, MODE_TRI, MODE_SQR);
  - the default duty constant.
- Sub-module wave_shaper: purely combinational phase/mode/duty -> sample, parametrised by OUT_W. wave_dds_gen owns the accumulator, shadow registers, output register and wrap/busy logic.

Test Plan (ACC_W=16, OUT_W=8):
1. Saw-up basic: after reset, load ftw=0x0100 mode=0, ena=1. -> busy clears the next cycle. value steps 0,1,2,…,255,0 one per cycle. wrap pulses once every 256 cycles, one cycle after acc goes 0xFF00 -> 0x0000.
2. Triangle: phase_rst, load ftw=0x0200 mode=2. -> value 0,4,8,…,252, then 255,251,…,3, then repeats. wrap every 128 cycles.
3. Square duty: load ftw=0x0100 mode=3 duty=64. -> per 256-cycle period, 64 cycles value=255 then 192 cycles value=0. duty=0 gives constant 0.
4. Glitch-free update: running saw-up ftw=0x0100, load ftw=0x0400 at phase 100. -> busy=1 and increment stays 1 until carry. The first post-wrap samples are 0,4,8. A second load before the wrap replaces the first (last wins).
5. Enable/phase_rst: drop ena for 10 cycles mid-ramp -> value and acc frozen, wrap=0. Then assert phase_rst with ena=1 -> value=0 next cycle and pending applied. ftw=0xFFFF -> saw-up phase decrements 255,254,… with wrap on every cycle but one per 2^16 phase.
6. Async reset mid-operation with busy=1 -> value, wrap and busy go to 0 immediately, without waiting for a clock edge. After release, load is needed before any output change, since ftw_act=0.
